// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline control blocks: forwarding-select
// encodings, the hazard controller state type and the default register-address width.
package cpu_pkg;

  localparam int RB_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/hz_shadow_stage.sv
// One registered shadow slot {rd, we, load, valid} tracking a pipeline stage's
// destination; a bubble clears the whole slot so a stale rd can never match.
module hz_shadow_stage
  import cpu_pkg::*;
#(
  parameter int RB = RB_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble,
  input  logic [RB-1:0] src_rd,
  input  logic          src_we,
  input  logic          src_load,
  input  logic          src_valid,
  output logic [RB-1:0] rd,
  output logic          we,
  output logic          is_load,
  output logic          valid
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      rd      <= '0;
      we      <= 1'b0;
      is_load <= 1'b0;
      valid   <= 1'b0;
    end else begin
      rd      <= src_rd;
      we      <= src_we;
      is_load <= src_load;
      valid   <= src_valid;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: post-reset fetch hold, load-use stall, taken-branch
// squash and registered forwarding selects, driven from shadow EX/MEM/WB slots.
//   state | meaning
//   HOLD  | fetch held after reset, IF/ID and ID/EX flushed, counts down RST_HOLD cycles
//   RUN   | normal issue; stall, squash and forwarding active
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int RB       = RB_DEF,
  parameter int RST_HOLD = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RB-1:0]    id_rs1,
  input  logic             id_rs1_use,
  input  logic [RB-1:0]    id_rs2,
  input  logic             id_rs2_use,
  input  logic [RB-1:0]    id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt;

  logic [RB-1:0] ex_rd, mem_rd, wb_rd;
  logic          ex_we, mem_we, wb_we;
  logic          ex_load, mem_load, wb_load;
  logic          ex_valid, mem_valid, wb_valid;
  logic          wb_unused;

  logic run, squash, stall, ex_bubble;
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;

  function automatic logic hit(input logic          use_src,
                               input logic [RB-1:0] src,
                               input logic          s_valid,
                               input logic          s_we,
                               input logic [RB-1:0] s_rd);
    return use_src && s_valid && s_we && (s_rd == src) && (src != '0);
  endfunction

  hz_shadow_stage #(.RB(RB)) u_ex (
    .clk(clk), .reset(reset), .bubble(ex_bubble),
    .src_rd(id_rd), .src_we(id_rd_we), .src_load(id_is_load), .src_valid(id_valid),
    .rd(ex_rd), .we(ex_we), .is_load(ex_load), .valid(ex_valid)
  );

  hz_shadow_stage #(.RB(RB)) u_mem (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .src_rd(ex_rd), .src_we(ex_we), .src_load(ex_load), .src_valid(ex_valid),
    .rd(mem_rd), .we(mem_we), .is_load(mem_load), .valid(mem_valid)
  );

  hz_shadow_stage #(.RB(RB)) u_wb (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .src_rd(mem_rd), .src_we(mem_we), .src_load(mem_load), .src_valid(mem_valid),
    .rd(wb_rd), .we(wb_we), .is_load(wb_load), .valid(wb_valid)
  );

  // WB is tracked for completeness of the shadow pipe; nothing forwards from it yet.
  assign wb_unused = ^{wb_rd, wb_we, wb_load, wb_valid, mem_load};

  assign run     = (state == RUN);
  assign rs1_ex  = hit(id_rs1_use, id_rs1, ex_valid, ex_we, ex_rd);
  assign rs2_ex  = hit(id_rs2_use, id_rs2, ex_valid, ex_we, ex_rd);
  assign rs1_mem = hit(id_rs1_use, id_rs1, mem_valid, mem_we, mem_rd);
  assign rs2_mem = hit(id_rs2_use, id_rs2, mem_valid, mem_we, mem_rd);

  // A taken branch squashes the ID instruction, so it can never also stall.
  assign squash    = run && ex_br_taken;
  assign stall     = run && !squash && id_valid && ex_load && (rs1_ex || rs2_ex);
  assign ex_bubble = !run || !id_valid || stall || squash;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HOLD;
      hold_cnt <= HOLD_INIT;
    end else begin
      state <= state_nxt;
      if (state == HOLD && hold_cnt != 4'd0)
        hold_cnt <= hold_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HOLD:    if (hold_cnt <= 4'd1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = HOLD;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    case (state)
      RUN: begin
        pc_we      = !stall;
        ifid_we    = !stall;
        ifid_flush = squash;
        idex_flush = stall || squash;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !run || !id_valid || stall || squash) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= rs1_ex ? FWD_EXMEM : (rs1_mem ? FWD_MEMWB : FWD_RF);
      fwd_b <= rs2_ex ? FWD_EXMEM : (rs2_mem ? FWD_MEMWB : FWD_RF);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random instruction
// streams, all checked against a cycle-level model of issue history.
module tb_hazard_ctrl;

  localparam int RST_HOLD = 2;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_rs1_use, id_rs2_use, id_rd_we, id_is_load;
  logic             ex_br_taken;
  logic             pc_we, ifid_we, ifid_flush, idex_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.RB(5), .RST_HOLD(RST_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       v;
  } slot_t;

  int checks   = 0;
  int failures = 0;

  // Model: remaining hold cycles, and the last three issued instructions (youngest first).
  int               hold_left;
  slot_t            hist[3];
  logic [CNT_W-1:0] m_cnt;
  logic [1:0]       m_fa, m_fb;

  logic             s_pc_we, s_ifid_we, s_ifid_flush, s_idex_flush;
  logic [1:0]       s_fa, s_fb;
  logic [CNT_W-1:0] s_cnt;

  function automatic logic m_hit(input logic u, input logic [4:0] src, input slot_t s);
    return u && s.v && s.we && (s.rd == src) && (src != 5'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hold_left = RST_HOLD;
    for (int i = 0; i < 3; i++) hist[i] = '{rd: 5'd0, we: 1'b0, ld: 1'b0, v: 1'b0};
    m_cnt = '0;
    m_fa  = 2'b00;
    m_fb  = 2'b00;
  endtask

  task automatic step(input logic rst, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic br);
    logic  run, sq, st, e_pc, e_ifwe, e_iff, e_idf;
    logic [1:0] n_fa, n_fb;
    slot_t ex, mem;
    reset = rst; id_valid = v;
    id_rs1 = rs1; id_rs1_use = u1; id_rs2 = rs2; id_rs2_use = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; ex_br_taken = br;
    @(negedge clk);
    ex  = hist[0];
    mem = hist[1];
    run = (hold_left == 0);
    sq  = run && br;
    st  = run && !sq && v && ex.ld && (m_hit(u1, rs1, ex) || m_hit(u2, rs2, ex));
    e_pc   = run && !st;
    e_ifwe = run && !st;
    e_iff  = !run || sq;
    e_idf  = !run || sq || st;
    s_pc_we = pc_we; s_ifid_we = ifid_we; s_ifid_flush = ifid_flush; s_idex_flush = idex_flush;
    s_fa = fwd_a; s_fb = fwd_b; s_cnt = stall_cnt;
    chk("m_pc_we", 32'(pc_we), 32'(e_pc));
    chk("m_ifid_we", 32'(ifid_we), 32'(e_ifwe));
    chk("m_ifid_flush", 32'(ifid_flush), 32'(e_iff));
    chk("m_idex_flush", 32'(idex_flush), 32'(e_idf));
    chk("m_fwd_a", 32'(fwd_a), 32'(m_fa));
    chk("m_fwd_b", 32'(fwd_b), 32'(m_fb));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (run && v && !st && !sq) begin
        n_fa = (m_hit(u1, rs1, ex) && !ex.ld) ? 2'b01 : (m_hit(u1, rs1, mem) ? 2'b10 : 2'b00);
        n_fb = (m_hit(u2, rs2, ex) && !ex.ld) ? 2'b01 : (m_hit(u2, rs2, mem) ? 2'b10 : 2'b00);
      end else begin
        n_fa = 2'b00;
        n_fb = 2'b00;
      end
      m_fa = n_fa;
      m_fb = n_fb;
      if (st && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (run && v && !st && !sq) hist[0] = '{rd: rd, we: we, ld: ld, v: 1'b1};
      else                        hist[0] = '{rd: 5'd0, we: 1'b0, ld: 1'b0, v: 1'b0};
      if (!run) hold_left = hold_left - 1;
    end
    #1;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0;
    id_rs1 = '0; id_rs1_use = 1'b0; id_rs2 = '0; id_rs2_use = 1'b0;
    id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0; ex_br_taken = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Reset held three cycles, then exactly two hold cycles.
    repeat (3) step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    nop();
    chk("hold1_pc_we", 32'(s_pc_we), 32'd0);
    chk("hold1_ifid_flush", 32'(s_ifid_flush), 32'd1);
    chk("hold1_idex_flush", 32'(s_idex_flush), 32'd1);
    nop();
    chk("hold2_pc_we", 32'(s_pc_we), 32'd0);
    nop();
    chk("run_pc_we", 32'(s_pc_we), 32'd1);
    chk("run_ifid_we", 32'(s_ifid_we), 32'd1);
    chk("run_flushes", 32'({s_ifid_flush, s_idex_flush}), 32'd0);
    chk("run_stall_cnt", 32'(s_cnt), 32'd0);

    // Load r5 followed by a reader of r5.
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("lu_pc_we", 32'(s_pc_we), 32'd0);
    chk("lu_ifid_we", 32'(s_ifid_we), 32'd0);
    chk("lu_idex_flush", 32'(s_idex_flush), 32'd1);
    step(1'b0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("lu_one_cycle", 32'(s_pc_we), 32'd1);
    chk("lu_stall_cnt", 32'(s_cnt), 32'd1);
    nop();
    chk("lu_fwd_a", 32'(s_fa), 32'd2);

    // ALU back-to-back, then with one independent instruction in between.
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    nop();
    chk("alu_ex_fwd_a", 32'(s_fa), 32'd1);
    chk("alu_ex_fwd_b", 32'(s_fb), 32'd1);
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    nop();
    chk("alu_mem_fwd_a", 32'(s_fa), 32'd2);
    chk("alu_mem_fwd_b", 32'(s_fb), 32'd2);

    // r0 producer (a load) then r0 consumer.
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("r0_no_stall", 32'(s_pc_we), 32'd1);
    nop();
    chk("r0_fwd_a", 32'(s_fa), 32'd0);

    // Taken branch coincides with a load-use match.
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
    chk("br_pc_we", 32'(s_pc_we), 32'd1);
    chk("br_ifid_flush", 32'(s_ifid_flush), 32'd1);
    chk("br_idex_flush", 32'(s_idex_flush), 32'd1);
    nop();
    chk("br_stall_cnt", 32'(s_cnt), 32'd1);
    chk("br_fwd", 32'({s_fa, s_fb}), 32'd0);

    // Reset during a stall cycle.
    step(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("rst_stall_pc_we", 32'(s_pc_we), 32'd0);
    nop();
    chk("rst_hold_pc_we", 32'(s_pc_we), 32'd0);
    chk("rst_stall_cnt", 32'(s_cnt), 32'd0);
    nop();
    step(1'b0, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("rst_no_stale_stall", 32'(s_pc_we), 32'd1);
    chk("rst_no_stale_flush", 32'(s_idex_flush), 32'd0);

    // Random instruction streams over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      logic r_ld;
      r_ld = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 9) != 0),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), r_ld | 1'($urandom_range(0, 1)), r_ld,
           ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
